// File: rtl/alu_rs.sv
// Reservation station for ALU-class instructions: holds dispatched ops until both
// sources are known, snoops the ALU and LSB CDBs, and issues the lowest-index ready entry.
module alu_rs #(
  parameter int RS_SIZE   = 16,
  parameter int OP_WIDTH  = 6,
  parameter int TAG_WIDTH = 5
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 ROB_clear,
  input  logic                 dispatch_enable,
  input  logic [OP_WIDTH-1:0]  dispatch_op,
  input  logic [31:0]          dispatch_imm,
  input  logic [31:0]          dispatch_pc,
  input  logic                 dispatch_reg1_valid,
  input  logic [31:0]          dispatch_reg1_data,
  input  logic [TAG_WIDTH-1:0] dispatch_reg1_tag,
  input  logic                 dispatch_reg2_valid,
  input  logic [31:0]          dispatch_reg2_data,
  input  logic [TAG_WIDTH-1:0] dispatch_reg2_tag,
  input  logic [TAG_WIDTH-1:0] dispatch_reg_dest_tag,
  input  logic                 ALU_cdb_valid,
  input  logic [TAG_WIDTH-1:0] ALU_cdb_tag,
  input  logic [31:0]          ALU_cdb_data,
  input  logic                 LSB_cdb_valid,
  input  logic [TAG_WIDTH-1:0] LSB_cdb_tag,
  input  logic [31:0]          LSB_cdb_data,
  output logic                 RS_full,
  output logic                 ALU_enable,
  output logic [OP_WIDTH-1:0]  ALU_op,
  output logic [31:0]          ALU_imm,
  output logic [31:0]          ALU_pc,
  output logic [31:0]          ALU_reg1_data,
  output logic [31:0]          ALU_reg2_data,
  output logic [TAG_WIDTH-1:0] ALU_reg_dest_tag
);

  localparam int IDX_W = $clog2(RS_SIZE);

  typedef struct packed {
    logic                 valid;
    logic [31:0]          data;
    logic [TAG_WIDTH-1:0] tag;
  } src_t;

  typedef struct packed {
    logic [OP_WIDTH-1:0]  op;
    logic [31:0]          imm;
    logic [31:0]          pc;
    logic [TAG_WIDTH-1:0] dest;
    src_t                 src1;
    src_t                 src2;
  } entry_t;

  logic [RS_SIZE-1:0] busy;
  entry_t             ent [RS_SIZE];

  logic [IDX_W-1:0]   free_idx;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_valid;
  logic               accept;
  logic [RS_SIZE-1:0] issue_mask;
  logic [RS_SIZE-1:0] alloc_mask;
  entry_t             new_entry;

  // Capture a pending source from the CDBs; tag 0 never matches, ALU bus wins a tie.
  function automatic src_t snoop(input src_t s);
    src_t r;
    r = s;
    if (!s.valid && s.tag != '0) begin
      if (ALU_cdb_valid && ALU_cdb_tag == s.tag) begin
        r.valid = 1'b1;
        r.data  = ALU_cdb_data;
      end else if (LSB_cdb_valid && LSB_cdb_tag == s.tag) begin
        r.valid = 1'b1;
        r.data  = LSB_cdb_data;
      end
    end
    return r;
  endfunction

  assign RS_full = &busy;
  assign accept  = dispatch_enable && !RS_full;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    free_idx   = '0;
    sel_idx    = '0;
    sel_valid  = 1'b0;
    issue_mask = '0;
    alloc_mask = '0;
    // Descending scan so the lowest index is the last one written.
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy[i]) free_idx = IDX_W'(i);
      if (busy[i] && ent[i].src1.valid && ent[i].src2.valid) begin
        sel_idx   = IDX_W'(i);
        sel_valid = 1'b1;
      end
    end
    if (sel_valid) issue_mask[sel_idx] = 1'b1;
    if (accept)    alloc_mask[free_idx] = 1'b1;
  end

  always_comb begin
    new_entry.op         = dispatch_op;
    new_entry.imm        = dispatch_imm;
    new_entry.pc         = dispatch_pc;
    new_entry.dest       = dispatch_reg_dest_tag;
    new_entry.src1       = snoop('{valid: dispatch_reg1_valid, data: dispatch_reg1_data,
                                   tag: dispatch_reg1_tag});
    new_entry.src2       = snoop('{valid: dispatch_reg2_valid, data: dispatch_reg2_data,
                                   tag: dispatch_reg2_tag});
  end

  // Control state and the registered issue port.
  always_ff @(posedge clk_in) begin
    // NOTE: sequential state uses <= so every register sees the pre-edge values of the others.
    if (rst_in) begin
      busy             <= '0;
      ALU_enable       <= 1'b0;
      ALU_op           <= '0;
      ALU_imm          <= '0;
      ALU_pc           <= '0;
      ALU_reg1_data    <= '0;
      ALU_reg2_data    <= '0;
      ALU_reg_dest_tag <= '0;
    end else if (ROB_clear) begin
      busy       <= '0;
      ALU_enable <= 1'b0;
    end else if (!rdy_in) begin
      ALU_enable <= 1'b0;
    end else begin
      ALU_enable <= sel_valid;
      if (sel_valid) begin
        ALU_op           <= ent[sel_idx].op;
        ALU_imm          <= ent[sel_idx].imm;
        ALU_pc           <= ent[sel_idx].pc;
        ALU_reg1_data    <= ent[sel_idx].src1.data;
        ALU_reg2_data    <= ent[sel_idx].src2.data;
        ALU_reg_dest_tag <= ent[sel_idx].dest;
      end
      // The free slot is taken from pre-edge busy, so an issued slot is never reused this edge.
      busy <= (busy & ~issue_mask) | alloc_mask;
    end
  end

  // NOTE: the entry payload has no reset; busy qualifies every read of it, so only busy is reset.
  always_ff @(posedge clk_in) begin
    if (!rst_in && !ROB_clear && rdy_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy[i]) begin
          ent[i].src1 <= snoop(ent[i].src1);
          ent[i].src2 <= snoop(ent[i].src2);
        end
      end
      if (accept) ent[free_idx] <= new_entry;
    end
  end

endmodule
